// File: rtl/rv_writeback_stage.sv
// Writeback stage: registers M-stage results, retires into the GPR file, resolves branch/jump prediction.
// Latency 1 cycle from capture to outputs; cu_stall_w_i holds the W register, cu_kill_w_i squashes it.
module rv_writeback_stage #(
  parameter int XLEN         = 32,
  parameter int GPR_ADDR_W   = 5,
  parameter int INSTRET_W    = 64,
  parameter bit JALR_PREDICT = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cu_kill_w_i,
  input  logic                  cu_stall_w_i,
  input  logic                  m_valid_i,
  input  logic                  m_gpr_wr_en_i,
  input  logic [GPR_ADDR_W-1:0] m_gpr_wr_addr_i,
  input  logic [XLEN-1:0]       m_gpr_wr_data_i,
  input  logic                  m_branch_i,
  input  logic                  m_jal_i,
  input  logic                  m_jalr_i,
  input  logic [XLEN-1:0]       m_target_pc_i,
  input  logic [XLEN-1:0]       m_next_pc_i,
  input  logic                  m_prediction_i,
  input  logic                  m_br_j_taken_i,
  output logic                  w_gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0] w_gpr_wr_addr_o,
  output logic [XLEN-1:0]       w_gpr_wr_data_o,
  output logic                  w_redirect_o,
  output logic [XLEN-1:0]       w_redirect_pc_o,
  output logic                  w_bp_update_o,
  output logic [XLEN-1:0]       w_bp_pc_o,
  output logic                  w_bp_taken_o,
  output logic [XLEN-1:0]       w_bp_target_o,
  output logic                  w_retire_o,
  output logic [INSTRET_W-1:0]  w_instret_o
);

  logic                  valid_q;
  logic                  wr_en_q;
  logic [GPR_ADDR_W-1:0] wr_addr_q;
  logic [XLEN-1:0]       wr_data_q;
  logic                  branch_q;
  logic                  jal_q;
  logic                  jalr_q;
  logic [XLEN-1:0]       target_q;
  logic [XLEN-1:0]       next_pc_q;
  logic                  pred_q;
  logic                  taken_q;
  logic                  redir_done_q;
  logic [INSTRET_W-1:0]  instret_q;

  logic retire;
  logic mispredict;
  logic redirect;

  always_comb begin
    mispredict = 1'b0;
    if (branch_q)      mispredict = (pred_q != taken_q);
    else if (jal_q)    mispredict = ~pred_q;
    else if (jalr_q)   mispredict = JALR_PREDICT ? ~pred_q : 1'b1;
  end

  assign retire   = valid_q & ~cu_stall_w_i & ~cu_kill_w_i;
  // Redirect may fire while stalled so fetch recovers early; redir_done_q stops a repeat.
  assign redirect = valid_q & ~cu_kill_w_i & mispredict & ~redir_done_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      valid_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      branch_q     <= 1'b0;
      jal_q        <= 1'b0;
      jalr_q       <= 1'b0;
      target_q     <= '0;
      next_pc_q    <= '0;
      pred_q       <= 1'b0;
      taken_q      <= 1'b0;
      redir_done_q <= 1'b0;
      instret_q    <= '0;
    end else begin
      if (!cu_stall_w_i) begin
        wr_en_q   <= m_gpr_wr_en_i;
        wr_addr_q <= m_gpr_wr_addr_i;
        wr_data_q <= m_gpr_wr_data_i;
        branch_q  <= m_branch_i;
        jal_q     <= m_jal_i;
        jalr_q    <= m_jalr_i;
        target_q  <= m_target_pc_i;
        next_pc_q <= m_next_pc_i;
        pred_q    <= m_prediction_i;
        taken_q   <= m_br_j_taken_i;
      end

      if (cu_kill_w_i)       valid_q <= 1'b0;
      else if (!cu_stall_w_i) valid_q <= m_valid_i;

      if (!cu_stall_w_i || cu_kill_w_i) redir_done_q <= 1'b0;
      else if (redirect)                redir_done_q <= 1'b1;

      if (retire) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_retire_o      = retire;
  assign w_gpr_wr_en_o   = retire & wr_en_q & (wr_addr_q != '0);
  assign w_gpr_wr_addr_o = wr_addr_q;
  assign w_gpr_wr_data_o = wr_data_q;
  assign w_redirect_o    = redirect;
  assign w_redirect_pc_o = taken_q ? target_q : next_pc_q;
  assign w_bp_update_o   = retire & (branch_q | jal_q | jalr_q);
  // Gated so an empty stage shows 0 rather than 0 - 4.
  assign w_bp_pc_o       = valid_q ? (next_pc_q - XLEN'(4)) : '0;
  assign w_bp_taken_o    = taken_q;
  assign w_bp_target_o   = target_q;
  assign w_instret_o     = instret_q;

endmodule

// File: tb/tb_rv_writeback_stage.sv
module tb_rv_writeback_stage;

  logic        clk;
  logic        arstn;
  logic        kill, stall;
  logic        m_valid, m_wr_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_branch, m_jal, m_jalr;
  logic [31:0] m_target, m_next_pc;
  logic        m_pred, m_taken;

  logic        gpr_en, redir, bp_upd, bp_tkn, retire;
  logic [4:0]  gpr_addr;
  logic [31:0] gpr_data, redir_pc, bp_pc, bp_tgt;
  logic [63:0] instret;

  logic        gpr_en4, redir4, bp_upd4, bp_tkn4, retire4;
  logic [4:0]  gpr_addr4;
  logic [31:0] gpr_data4, redir_pc4, bp_pc4, bp_tgt4;
  logic [3:0]  instret4;

  int passed = 0;
  int total  = 0;

  rv_writeback_stage #(.XLEN(32), .GPR_ADDR_W(5), .INSTRET_W(64), .JALR_PREDICT(1'b0)) dut (
    .clk_i(clk), .arstn_i(arstn), .cu_kill_w_i(kill), .cu_stall_w_i(stall),
    .m_valid_i(m_valid), .m_gpr_wr_en_i(m_wr_en), .m_gpr_wr_addr_i(m_addr), .m_gpr_wr_data_i(m_data),
    .m_branch_i(m_branch), .m_jal_i(m_jal), .m_jalr_i(m_jalr), .m_target_pc_i(m_target),
    .m_next_pc_i(m_next_pc), .m_prediction_i(m_pred), .m_br_j_taken_i(m_taken),
    .w_gpr_wr_en_o(gpr_en), .w_gpr_wr_addr_o(gpr_addr), .w_gpr_wr_data_o(gpr_data),
    .w_redirect_o(redir), .w_redirect_pc_o(redir_pc), .w_bp_update_o(bp_upd), .w_bp_pc_o(bp_pc),
    .w_bp_taken_o(bp_tkn), .w_bp_target_o(bp_tgt), .w_retire_o(retire), .w_instret_o(instret)
  );

  rv_writeback_stage #(.XLEN(32), .GPR_ADDR_W(5), .INSTRET_W(4), .JALR_PREDICT(1'b1)) dut4 (
    .clk_i(clk), .arstn_i(arstn), .cu_kill_w_i(kill), .cu_stall_w_i(stall),
    .m_valid_i(m_valid), .m_gpr_wr_en_i(m_wr_en), .m_gpr_wr_addr_i(m_addr), .m_gpr_wr_data_i(m_data),
    .m_branch_i(m_branch), .m_jal_i(m_jal), .m_jalr_i(m_jalr), .m_target_pc_i(m_target),
    .m_next_pc_i(m_next_pc), .m_prediction_i(m_pred), .m_br_j_taken_i(m_taken),
    .w_gpr_wr_en_o(gpr_en4), .w_gpr_wr_addr_o(gpr_addr4), .w_gpr_wr_data_o(gpr_data4),
    .w_redirect_o(redir4), .w_redirect_pc_o(redir_pc4), .w_bp_update_o(bp_upd4), .w_bp_pc_o(bp_pc4),
    .w_bp_taken_o(bp_tkn4), .w_bp_target_o(bp_tgt4), .w_retire_o(retire4), .w_instret_o(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_m(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic br, input logic jl, input logic jr, input logic [31:0] tg,
                       input logic [31:0] np, input logic pr, input logic tk);
    m_valid = v; m_wr_en = we; m_addr = a; m_data = d;
    m_branch = br; m_jal = jl; m_jalr = jr; m_target = tg;
    m_next_pc = np; m_pred = pr; m_taken = tk;
  endtask

  initial begin
    arstn = 1'b0; kill = 1'b0; stall = 1'b0;
    set_m(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_gpr_en", gpr_en, 0);
    chk("rst_gpr_addr", gpr_addr, 0);
    chk("rst_gpr_data", gpr_data, 0);
    chk("rst_redirect", redir, 0);
    chk("rst_redirect_pc", redir_pc, 0);
    chk("rst_bp_update", bp_upd, 0);
    chk("rst_bp_pc", bp_pc, 0);
    chk("rst_retire", retire, 0);
    chk("rst_instret", instret, 0);
    @(negedge clk);

    // release reset: nothing retires in the first cycle
    arstn = 1'b1;
    #1;
    chk("rel_retire", retire, 0);
    chk("rel_gpr_en", gpr_en, 0);
    chk("rel_redirect", redir, 0);
    @(negedge clk);

    // ALU rd=5 retires; next M op writes rd=0
    set_m(1, 1, 5'd0, 32'h1234, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("alu_retire", retire, 1);
    chk("alu_gpr_en", gpr_en, 1);
    chk("alu_gpr_addr", gpr_addr, 5);
    chk("alu_gpr_data", gpr_data, 32'hDEADBEEF);
    chk("alu_instret_before", instret, 0);
    @(negedge clk);

    set_m(1, 0, 5'd0, 32'h0, 1, 0, 0, 32'h100, 32'h48, 0, 1);
    #1;
    chk("x0_retire", retire, 1);
    chk("x0_gpr_en", gpr_en, 0);
    chk("x0_instret", instret, 1);
    @(negedge clk);

    // mispredicted branch, no stall
    set_m(1, 0, 5'd0, 32'h0, 1, 0, 0, 32'h200, 32'h88, 0, 1);
    #1;
    chk("br_redirect", redir, 1);
    chk("br_redirect_pc", redir_pc, 32'h100);
    chk("br_bp_update", bp_upd, 1);
    chk("br_bp_pc", bp_pc, 32'h44);
    chk("br_bp_taken", bp_tkn, 1);
    chk("br_bp_target", bp_tgt, 32'h100);
    chk("br_instret", instret, 2);
    @(negedge clk);

    // same kind of mispredict, held 3 stall cycles
    stall = 1'b1;
    #1;
    chk("st1_redirect", redir, 1);
    chk("st1_redirect_pc", redir_pc, 32'h200);
    chk("st1_retire", retire, 0);
    chk("st1_bp_update", bp_upd, 0);
    chk("st1_instret", instret, 3);
    @(negedge clk);
    #1;
    chk("st2_redirect", redir, 0);
    chk("st2_retire", retire, 0);
    @(negedge clk);
    #1;
    chk("st3_redirect", redir, 0);
    chk("st3_bp_update", bp_upd, 0);
    @(negedge clk);

    stall = 1'b0;
    set_m(1, 1, 5'd7, 32'hCAFE, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("strel_redirect", redir, 0);
    chk("strel_retire", retire, 1);
    chk("strel_bp_update", bp_upd, 1);
    chk("strel_bp_pc", bp_pc, 32'h84);
    chk("strel_instret", instret, 3);
    @(negedge clk);

    // kill together with stall on a valid write
    stall = 1'b1; kill = 1'b1;
    #1;
    chk("kill_retire", retire, 0);
    chk("kill_gpr_en", gpr_en, 0);
    chk("kill_redirect", redir, 0);
    chk("kill_instret", instret, 4);
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("postkill_retire", retire, 0);
    chk("postkill_gpr_en", gpr_en, 0);
    chk("postkill_addr_held", gpr_addr, 7);
    chk("postkill_instret", instret, 4);
    @(negedge clk);

    // JALR predicted taken: redirects only when JALR_PREDICT=0
    stall = 1'b0;
    set_m(1, 0, 5'd0, 32'h0, 0, 0, 1, 32'h300, 32'h104, 1, 1);
    #1;
    chk("prejalr_retire", retire, 0);
    @(negedge clk);

    set_m(1, 0, 5'd0, 32'h0, 0, 1, 0, 32'h400, 32'h204, 1, 1);
    #1;
    chk("jalr_redirect", redir, 1);
    chk("jalr_redirect_pc", redir_pc, 32'h300);
    chk("jalr_trusted_redirect", redir4, 0);
    chk("jalr_bp_update", bp_upd, 1);
    chk("jalr_bp_pc", bp_pc, 32'h100);
    chk("jalr_instret", instret, 4);
    @(negedge clk);

    set_m(0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("jal_redirect", redir, 0);
    chk("jal_bp_update", bp_upd, 1);
    chk("jal_bp_target", bp_tgt, 32'h400);
    chk("jal_instret", instret, 5);
    @(negedge clk);

    set_m(1, 1, 5'd1, 32'h55, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("bubble_retire", retire, 0);
    chk("bubble_instret", instret, 6);
    chk("bubble_instret4", instret4, 6);
    @(negedge clk);

    // 11 more retires bring the total to 17; the 4-bit counter wraps to 1
    for (int k = 0; k < 11; k++) begin
      #1;
      chk("wrap_retire", retire, 1);
      if (k == 10) m_valid = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("wrap_instret4", instret4, 1);
    chk("wrap_instret64", instret, 17);
    chk("wrap_idle_retire", retire, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
